// File: rtl/pq_cmd_scheduler_if.sv
// Handshake and queue-control bundle between the command scheduler and its neighbours.
// master = scheduler side, slave = producer/consumer/queue side.
interface pq_cmd_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 256
);
  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);

  logic                  s_enq_valid;
  logic                  s_enq_ready;
  logic [DATA_WIDTH-1:0] s_enq_data;
  logic                  i_deq_req;
  logic                  m_deq_valid;
  logic                  m_deq_ready;
  logic [DATA_WIDTH-1:0] m_deq_data;
  logic                  o_wrt;
  logic                  o_read;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_full;
  logic                  i_empty;
  logic [DATA_WIDTH-1:0] i_top;
  logic [CNT_W-1:0]      o_count;
  logic                  o_busy;

  modport master (
    input  s_enq_valid, s_enq_data, i_deq_req, m_deq_ready, i_full, i_empty, i_top,
    output s_enq_ready, m_deq_valid, m_deq_data, o_wrt, o_read, o_data, o_count, o_busy
  );

  modport slave (
    output s_enq_valid, s_enq_data, i_deq_req, m_deq_ready, i_full, i_empty, i_top,
    input  s_enq_ready, m_deq_valid, m_deq_data, o_wrt, o_read, o_data, o_count, o_busy
  );
endinterface

// File: rtl/pq_cmd_scheduler.sv
// Serialises enqueue/dequeue requests into single-cycle write/read controls for the
// priority-queue register array, merging coincident requests into a replace.
module pq_cmd_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 256,
  parameter int ENQ_GAP    = 128,
  parameter int DEQ_GAP    = 1
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  pq_cmd_scheduler_if.master   bus
);
  localparam int CNT_W   = $clog2(QUEUE_SIZE + 1);
  localparam int GAP_MAX = (ENQ_GAP > DEQ_GAP) ? ENQ_GAP : DEQ_GAP;
  localparam int GAP_W   = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);

  localparam logic [GAP_W-1:0] ENQ_GAP_L = GAP_W'(ENQ_GAP);
  localparam logic [GAP_W-1:0] DEQ_GAP_L = GAP_W'(DEQ_GAP);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(QUEUE_SIZE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]            state_reg;
  logic                  op_wrt_reg;
  logic                  op_read_reg;
  logic [GAP_W-1:0]      gap_reg;
  logic                  wrt_reg;
  logic                  read_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  deq_valid_reg;
  logic [DATA_WIDTH-1:0] deq_data_reg;
  logic [CNT_W-1:0]      count_reg;

  logic                  is_idle;
  logic                  deq_ok;
  logic                  enq_ok;
  logic [GAP_W-1:0]      issue_gap;

  // A full queue still takes an enqueue when the same decision pops the head.
  always_comb begin
    is_idle   = (state_reg == ST_IDLE);
    deq_ok    = bus.i_deq_req && !bus.i_empty && !deq_valid_reg;
    enq_ok    = bus.s_enq_valid && (!bus.i_full || deq_ok);
    issue_gap = op_wrt_reg ? ENQ_GAP_L : DEQ_GAP_L;
  end

  assign bus.s_enq_ready = is_idle && enq_ok && !i_RST;
  assign bus.o_wrt       = wrt_reg;
  assign bus.o_read      = read_reg;
  assign bus.o_data      = data_reg;
  assign bus.m_deq_valid = deq_valid_reg;
  assign bus.m_deq_data  = deq_data_reg;
  assign bus.o_count     = count_reg;
  assign bus.o_busy      = !is_idle;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_reg     <= ST_IDLE;
      op_wrt_reg    <= 1'b0;
      op_read_reg   <= 1'b0;
      gap_reg       <= '0;
      wrt_reg       <= 1'b0;
      read_reg      <= 1'b0;
      data_reg      <= '0;
      deq_valid_reg <= 1'b0;
      deq_data_reg  <= '0;
      count_reg     <= '0;
    end else begin
      if (deq_valid_reg && bus.m_deq_ready) begin
        deq_valid_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (enq_ok || deq_ok) begin
            op_wrt_reg  <= enq_ok;
            op_read_reg <= deq_ok;
            wrt_reg     <= enq_ok;
            read_reg    <= deq_ok;
            if (enq_ok) begin
              data_reg <= bus.s_enq_data;
            end
            state_reg <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          wrt_reg  <= 1'b0;
          read_reg <= 1'b0;
          // i_top still shows the pre-operation head on this edge.
          if (op_read_reg) begin
            deq_data_reg  <= bus.i_top;
            deq_valid_reg <= 1'b1;
          end
          if (op_wrt_reg && !op_read_reg && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_W'(1);
          end else if (op_read_reg && !op_wrt_reg && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_W'(1);
          end
          if (issue_gap == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            gap_reg   <= issue_gap;
            state_reg <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          gap_reg <= gap_reg - GAP_W'(1);
          if (gap_reg == GAP_W'(1)) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule
